// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stalls, branch
// flush, memory-wait freeze and registered EX forwarding selects.
module hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int PERF_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_addr1,
    input  logic [4:0]        id_addr2,
    input  logic [4:0]        id_rd,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              mem_ready,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              stall_all,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic [0:0] {
        RUN,
        STALL_LU
    } state_t;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_CYCLES - 1);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [4:0]        r_exRd;
    logic              r_exLoad;
    logic [4:0]        r_memRd;
    logic [1:0]        r_fwdA;
    logic [1:0]        r_fwdB;
    logic [PERF_W-1:0] r_perfCnt;

    logic w_loadUse;
    logic w_stallIfId;
    logic w_bubbleEx;
    logic w_flushIfId;
    logic w_stallAll;

    // The EX-stage match wins because it holds the younger result.
    function automatic logic [1:0] fwdSel(input logic [4:0] addr,
                                          input logic [4:0] exRd,
                                          input logic [4:0] memRd);
        logic [1:0] sel;
        sel = 2'b00;
        if (addr != 5'd0 && addr == exRd)
            sel = 2'b01;
        else if (addr != 5'd0 && addr == memRd)
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        w_loadUse   = id_valid & r_exLoad & (r_exRd != 5'd0) &
                      ((r_exRd == id_addr1) | (r_exRd == id_addr2));
        w_stallIfId = 1'b0;
        w_bubbleEx  = 1'b0;
        w_flushIfId = 1'b0;
        w_stallAll  = 1'b0;
        if (!rst) begin
            w_stallAll = ~mem_ready;
            if (mem_ready) begin
                case (r_state)
                    RUN: begin
                        if (ex_branch_taken) begin
                            w_flushIfId = 1'b1;
                            w_bubbleEx  = 1'b1;
                        end else if (w_loadUse) begin
                            w_stallIfId = 1'b1;
                            w_bubbleEx  = 1'b1;
                        end
                    end
                    // EX only holds a bubble here, so a taken branch cannot occur.
                    STALL_LU: begin
                        w_stallIfId = 1'b1;
                        w_bubbleEx  = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_cnt     <= 3'd0;
            r_exRd    <= 5'd0;
            r_exLoad  <= 1'b0;
            r_memRd   <= 5'd0;
            r_fwdA    <= 2'b00;
            r_fwdB    <= 2'b00;
            r_perfCnt <= '0;
        end else begin
            if ((w_stallIfId | w_stallAll) && r_perfCnt != {PERF_W{1'b1}})
                r_perfCnt <= r_perfCnt + 1'b1;

            if (mem_ready) begin
                case (r_state)
                    RUN: begin
                        if (!ex_branch_taken && w_loadUse && LOAD_USE_CYCLES > 1) begin
                            r_state <= STALL_LU;
                            r_cnt   <= STALL_RELOAD;
                        end
                    end
                    STALL_LU: begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1)
                            r_state <= RUN;
                    end
                    default: r_state <= RUN;
                endcase

                r_memRd <= r_exRd;
                if (w_bubbleEx || !id_valid) begin
                    r_exRd   <= 5'd0;
                    r_exLoad <= 1'b0;
                end else begin
                    r_exRd   <= id_rd;
                    r_exLoad <= id_is_load;
                end

                if (w_bubbleEx) begin
                    r_fwdA <= 2'b00;
                    r_fwdB <= 2'b00;
                end else begin
                    r_fwdA <= fwdSel(id_addr1, r_exRd, r_memRd);
                    r_fwdB <= fwdSel(id_addr2, r_exRd, r_memRd);
                end
            end
        end
    end

    assign stall_if_id    = w_stallIfId;
    assign bubble_ex      = w_bubbleEx;
    assign flush_if_id    = w_flushIfId;
    assign stall_all      = w_stallAll;
    assign fwd_a          = r_fwdA;
    assign fwd_b          = r_fwdB;
    assign perf_stall_cnt = r_perfCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; one instance with a single-cycle load-use
// stall and one with a three-cycle stall share the same stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_addr1;
    logic [4:0] id_addr2;
    logic [4:0] id_rd;
    logic       id_is_load;
    logic       ex_branch_taken;
    logic       mem_ready;

    logic        s1, b1, f1, a1;
    logic [1:0]  fa1, fb1;
    logic [15:0] p1;
    logic        s3, b3, f3, a3;
    logic [1:0]  fa3, fb3;
    logic [15:0] p3;

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_CYCLES(1), .PERF_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_addr1(id_addr1),
        .id_addr2(id_addr2), .id_rd(id_rd), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_if_id(s1), .bubble_ex(b1), .flush_if_id(f1), .stall_all(a1),
        .fwd_a(fa1), .fwd_b(fb1), .perf_stall_cnt(p1)
    );

    hazard_ctrl #(.LOAD_USE_CYCLES(3), .PERF_W(16)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_addr1(id_addr1),
        .id_addr2(id_addr2), .id_rd(id_rd), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .stall_if_id(s3), .bubble_ex(b3), .flush_if_id(f3), .stall_all(a3),
        .fwd_a(fa3), .fwd_b(fb3), .perf_stall_cnt(p3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling them mid-cycle.
    task automatic settle();
        #3;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] ra,
                                 input logic [4:0] rb, input logic [4:0] rd,
                                 input logic ld, input logic br, input logic mr);
        id_valid        = v;
        id_addr1        = ra;
        id_addr2        = rb;
        id_rd           = rd;
        id_is_load      = ld;
        ex_branch_taken = br;
        mem_ready       = mr;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        rst = 1'b0;
    endtask

    task automatic checkCtl3(input string tag, input logic s, input logic b,
                             input logic f, input logic a);
        checkOutput({tag, ".stall3"}, s3, s);
        checkOutput({tag, ".bubble3"}, b3, b);
        checkOutput({tag, ".flush3"}, f3, f);
        checkOutput({tag, ".all3"}, a3, a);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        settle();
        checkOutput("rst.comb1", {28'd0, s1, b1, f1, a1}, 32'd0);
        checkCtl3("rst", 0, 0, 0, 0);
        checkOutput("rst.fwd3", {28'd0, fa3, fb3}, 32'd0);
        checkOutput("rst.perf3", p3, 0);
        rst = 1'b0;

        // add x5,x1,x2 ; add x6,x5,x1 -> EX forward on operand A
        applyStimulus(1, 1, 2, 5, 0, 0, 1);
        tick();
        applyStimulus(1, 5, 1, 6, 0, 0, 1);
        settle();
        checkCtl3("t1", 0, 0, 0, 0);
        tick();
        checkOutput("t1.fwd_a", fa1, 2'b01);
        checkOutput("t1.fwd_b", fb1, 2'b00);
        // Freeze with a non-matching ID instruction: selects must hold.
        applyStimulus(1, 9, 9, 0, 0, 0, 0);
        settle();
        checkOutput("t1.frz.all", a1, 1);
        tick();
        checkOutput("t1.frz.fwd_a", fa1, 2'b01);

        // add x5 ; nop ; sub x7,x3,x5 -> MEM forward on operand B
        doReset();
        applyStimulus(1, 1, 2, 5, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 3, 5, 7, 0, 0, 1);
        settle();
        checkOutput("t2.stall", s1, 0);
        tick();
        checkOutput("t2.fwd_a", fa1, 2'b00);
        checkOutput("t2.fwd_b", fb1, 2'b10);

        // lw x5 ; add x7,x5,x5 on both instances
        doReset();
        applyStimulus(1, 1, 0, 5, 1, 0, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        settle();
        checkOutput("t3.c1.stall1", s1, 1);
        checkOutput("t3.c1.bubble1", b1, 1);
        checkCtl3("t4.c1", 1, 1, 0, 0);
        tick();
        settle();
        checkOutput("t3.c2.stall1", s1, 0);
        checkOutput("t3.c2.bubble1", b1, 0);
        checkCtl3("t4.c2", 1, 1, 0, 0);
        tick();
        checkOutput("t3.fwd_a", fa1, 2'b10);
        checkOutput("t3.fwd_b", fb1, 2'b10);
        checkOutput("t3.perf", p1, 1);
        settle();
        checkCtl3("t4.c3", 1, 1, 0, 0);
        tick();
        settle();
        checkCtl3("t4.c4", 0, 0, 0, 0);
        checkOutput("t4.perf", p3, 3);
        tick();
        checkOutput("t4.fwd", {30'd0, fa3 | fb3}, 32'd0);

        // Branch taken while a load-use pair is present: flush wins
        doReset();
        applyStimulus(1, 1, 0, 5, 1, 0, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 1, 1);
        settle();
        checkCtl3("t5.br", 0, 1, 1, 0);
        checkOutput("t5.br.flush1", f1, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        settle();
        checkCtl3("t5.after", 0, 0, 0, 0);
        checkOutput("t5.perf3", p3, 0);

        // lw x0 then a reader of x0 never stalls
        doReset();
        applyStimulus(1, 1, 0, 0, 1, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 7, 0, 0, 1);
        settle();
        checkCtl3("t5.x0", 0, 0, 0, 0);

        // Memory wait during STALL_LU with cnt=2
        doReset();
        applyStimulus(1, 1, 0, 5, 1, 0, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5, 5, 7, 0, 0, 0);
            settle();
            checkCtl3($sformatf("t6.frz%0d", i), 0, 0, 0, 1);
            tick();
        end
        checkOutput("t6.perf.frz", p3, 5);
        checkOutput("t6.perf1.frz", p1, 5);
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        settle();
        checkCtl3("t6.res1", 1, 1, 0, 0);
        tick();
        settle();
        checkCtl3("t6.res2", 1, 1, 0, 0);
        tick();
        settle();
        checkCtl3("t6.done", 0, 0, 0, 0);
        checkOutput("t6.perf", p3, 7);

        // Reset asserted mid-STALL_LU during a freeze
        applyStimulus(1, 1, 0, 5, 1, 0, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        tick();
        applyStimulus(1, 5, 5, 7, 0, 0, 0);
        rst = 1'b1;
        settle();
        checkCtl3("t7.inrst", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1, 5, 5, 7, 0, 0, 1);
        settle();
        checkCtl3("t7.post", 0, 0, 0, 0);
        checkOutput("t7.perf", p3, 0);
        checkOutput("t7.fwd", {28'd0, fa3, fb3}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
